// File: rtl/ldtu_enc_pkg.sv
// Shared encodings for the LiTe-DTU baseline/signal encoder: FSM state codes
// and word-type codes reported alongside each closed word.
package ldtu_enc_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_BAS     = 3'd1,
    ST_BAS_BIS = 3'd2,
    ST_SIG     = 3'd3,
    ST_SIG_BIS = 3'd4
  } enc_state_e;

  localparam logic WT_BAS = 1'b0;
  localparam logic WT_SIG = 1'b1;

endpackage

// File: rtl/ldtu_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module ldtu_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ldtu_encoder_fsm_param.sv
// LiTe-DTU baseline/signal encoder FSM with parametrised group sizes, word
// completion strobes and saturating per-type word counters.
module ldtu_encoder_fsm_param
  import ldtu_enc_pkg::*;
#(
  parameter int BAS_GROUP = 5,
  parameter int SIG_GROUP = 2,
  parameter int IDX_W     = ($clog2((BAS_GROUP > SIG_GROUP) ? BAS_GROUP : SIG_GROUP) < 1) ? 1 :
                             $clog2((BAS_GROUP > SIG_GROUP) ? BAS_GROUP : SIG_GROUP),
  parameter int CNT_W     = 16
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               enable,
  input  logic               baseline_flag,
  input  logic               clear_cnt,
  output logic [2:0]         Current_state,
  output logic [IDX_W-1:0]   group_idx,
  output logic               word_done,
  output logic               word_type,
  output logic [IDX_W:0]     word_len,
  output logic [CNT_W-1:0]   bas_word_cnt,
  output logic [CNT_W-1:0]   sig_word_cnt
);

  localparam int LEN_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] BAS_LAST = IDX_W'(BAS_GROUP - 1);
  localparam logic [IDX_W-1:0] SIG_LAST = IDX_W'(SIG_GROUP - 1);

  enc_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic             done_q, done_d;
  logic             type_q, type_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             bas_inc, sig_inc;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    type_d  = type_q;
    len_d   = len_q;
    idx_inc = idx_q + IDX_W'(1);

    case (state_q)
      ST_IDLE: if (enable) begin
        state_d = baseline_flag ? ST_BAS : ST_SIG;
        idx_d   = '0;
      end
      ST_BAS: if (enable) begin
        idx_d = (idx_q == BAS_LAST) ? '0 : idx_inc;
        if (!baseline_flag) begin
          state_d = ST_BAS_BIS;
          if (idx_q != BAS_LAST) begin
            done_d = 1'b1;
            type_d = WT_BAS;
            len_d  = {1'b0, idx_q} + LEN_W'(1);
          end
        end
      end
      ST_BAS_BIS: if (enable) begin
        state_d = baseline_flag ? ST_SIG_BIS : ST_SIG;
        idx_d   = '0;
      end
      ST_SIG: if (enable) begin
        idx_d = (idx_q == SIG_LAST) ? '0 : idx_inc;
        if (baseline_flag) begin
          state_d = ST_SIG_BIS;
          if (idx_q != SIG_LAST) begin
            done_d = 1'b1;
            type_d = WT_SIG;
            len_d  = {1'b0, idx_q} + LEN_W'(1);
          end
        end
      end
      ST_SIG_BIS: if (enable) begin
        state_d = baseline_flag ? ST_BAS : ST_BAS_BIS;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    // A full word closes on whichever edge lands a group on its last slot;
    // this also covers every SIG entry when SIG_GROUP is 1.
    if (enable && (((state_d == ST_BAS) && (idx_d == BAS_LAST)) ||
                   ((state_d == ST_SIG) && (idx_d == SIG_LAST)))) begin
      done_d = 1'b1;
      type_d = (state_d == ST_SIG) ? WT_SIG : WT_BAS;
      len_d  = (state_d == ST_SIG) ? LEN_W'(SIG_GROUP) : LEN_W'(BAS_GROUP);
    end

    bas_inc = done_d && (type_d == WT_BAS);
    sig_inc = done_d && (type_d == WT_SIG);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      type_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      type_q  <= type_d;
      len_q   <= len_d;
    end
  end

  ldtu_sat_counter #(.CNT_W(CNT_W)) u_bas_cnt (
    .clk   (CLK),
    .rst_n (reset),
    .inc   (bas_inc),
    .clr   (clear_cnt),
    .cnt   (bas_word_cnt)
  );

  ldtu_sat_counter #(.CNT_W(CNT_W)) u_sig_cnt (
    .clk   (CLK),
    .rst_n (reset),
    .inc   (sig_inc),
    .clr   (clear_cnt),
    .cnt   (sig_word_cnt)
  );

  assign Current_state = state_q;
  assign group_idx     = idx_q;
  assign word_done     = done_q;
  assign word_type     = type_q;
  assign word_len      = len_q;

endmodule
